// File: rtl/ahbl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_arbiter_pkg
// Brief    : Shared AHB-lite encodings and address-phase field offsets.
// Revision : 1.0 - initial release
// ============================================================================
package ahbl_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'b00,
    HTRANS_BUSY = 2'b01,
    HTRANS_NSEQ = 2'b10,
    HTRANS_SEQ  = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Bit offsets of each field inside a packed address phase
  // {haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock}.
  localparam int AP_LOCK  = 0;
  localparam int AP_PROT  = 1;
  localparam int AP_BURST = 5;
  localparam int AP_SIZE  = 8;
  localparam int AP_TRANS = 11;
  localparam int AP_WRITE = 13;
  localparam int AP_ADDR  = 14;

endpackage
`default_nettype wire

// File: rtl/ahbl_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_arbiter_if
// Brief    : Upstream (N masters) and downstream (one slave) AHB-lite bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ahbl_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic [N_PORTS-1:0]        src_hready;
  logic [N_PORTS-1:0]        src_hready_resp;
  logic [N_PORTS-1:0]        src_hresp;
  logic [N_PORTS*W_ADDR-1:0] src_haddr;
  logic [N_PORTS-1:0]        src_hwrite;
  logic [N_PORTS*2-1:0]      src_htrans;
  logic [N_PORTS*3-1:0]      src_hsize;
  logic [N_PORTS*3-1:0]      src_hburst;
  logic [N_PORTS*4-1:0]      src_hprot;
  logic [N_PORTS-1:0]        src_hmastlock;
  logic [N_PORTS*W_DATA-1:0] src_hwdata;
  logic [N_PORTS*W_DATA-1:0] src_hrdata;

  logic                      dst_hready;
  logic                      dst_hready_resp;
  logic                      dst_hresp;
  logic [W_ADDR-1:0]         dst_haddr;
  logic                      dst_hwrite;
  logic [1:0]                dst_htrans;
  logic [2:0]                dst_hsize;
  logic [2:0]                dst_hburst;
  logic [3:0]                dst_hprot;
  logic                      dst_hmastlock;
  logic [W_DATA-1:0]         dst_hwdata;
  logic [W_DATA-1:0]         dst_hrdata;

  // Arbiter view: slave to the upstream masters, master to the downstream slave.
  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    output src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata
  );

  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    input  src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata
  );
endinterface
`default_nettype wire

// File: rtl/onehot_mux.sv
`default_nettype none
// ============================================================================
// Module   : onehot_mux
// Brief    : AND-OR multiplexer of N W-bit lanes under a one-hot select.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N*W-1:0] data_i,
  input  logic [N-1:0]   sel_i,
  output logic [W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      data_o = data_o | (data_i[i*W +: W] & {W{sel_i[i]}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/onehot_priority.sv
`default_nettype none
// ============================================================================
// Module   : onehot_priority
// Brief    : N-bit request vector to one-hot grant, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_priority #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_arbiter
// Brief    : AHB-lite N:1 fixed-priority arbiter with per-port address buffers.
// Revision : 1.0 - initial release
// ============================================================================
module ahbl_arbiter
  import ahbl_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ahbl_arbiter_if.slave  bus
);

  localparam int W_AP = W_ADDR + 14;
  localparam logic [N_PORTS-1:0] PORT0_SEL = N_PORTS'(1);

  logic [N_PORTS-1:0]      live_req;
  logic [N_PORTS-1:0]      req;
  logic [N_PORTS-1:0]      capture;
  logic [N_PORTS-1:0]      prio_gnt;
  logic [N_PORTS-1:0]      grant_a;
  logic [N_PORTS-1:0]      mux_sel;
  logic [N_PORTS*W_AP-1:0] sel_ap;
  logic [W_AP-1:0]         dst_ap;
  logic                    locked_req;

  logic [N_PORTS-1:0]      buf_valid_q, buf_valid_d;
  logic [N_PORTS-1:0]      grant_dp_q;
  logic                    lock_dp_q;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic [W_AP-1:0] live_ap;
    logic [W_AP-1:0] buf_ap_q;

    assign live_ap = {bus.src_haddr[i*W_ADDR +: W_ADDR], bus.src_hwrite[i],
                      bus.src_htrans[2*i +: 2], bus.src_hsize[3*i +: 3],
                      bus.src_hburst[3*i +: 3], bus.src_hprot[4*i +: 4],
                      bus.src_hmastlock[i]};

    // A stalled master has hready low, so only the buffer can represent it.
    assign live_req[i] = bus.src_hready[i] && (bus.src_htrans[2*i +: 2] != HTRANS_IDLE);
    assign req[i]      = buf_valid_q[i] | live_req[i];
    assign capture[i]  = live_req[i] && !buf_valid_q[i] &&
                         (!bus.dst_hready_resp || !grant_a[i]);
    assign sel_ap[i*W_AP +: W_AP] = buf_valid_q[i] ? buf_ap_q : live_ap;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_ap_q <= '0;
      end else if (capture[i]) begin
        buf_ap_q <= live_ap;
      end
    end
  end

  onehot_priority #(.N(N_PORTS)) u_prio (
    .req_i (req),
    .gnt_o (prio_gnt)
  );

  // A locked data phase keeps the bus as long as its owner keeps requesting.
  assign locked_req = lock_dp_q && |(grant_dp_q & req);
  assign grant_a    = locked_req ? grant_dp_q : prio_gnt;
  assign mux_sel    = (grant_a != '0) ? grant_a : PORT0_SEL;

  onehot_mux #(.N(N_PORTS), .W(W_AP)) u_ap_mux (
    .data_i (sel_ap),
    .sel_i  (mux_sel),
    .data_o (dst_ap)
  );

  onehot_mux #(.N(N_PORTS), .W(W_DATA)) u_wdata_mux (
    .data_i (bus.src_hwdata),
    .sel_i  (grant_dp_q),
    .data_o (bus.dst_hwdata)
  );

  assign bus.dst_haddr     = dst_ap[AP_ADDR +: W_ADDR];
  assign bus.dst_hwrite    = dst_ap[AP_WRITE];
  assign bus.dst_htrans    = (grant_a != '0) ? dst_ap[AP_TRANS +: 2] : HTRANS_IDLE;
  assign bus.dst_hsize     = dst_ap[AP_SIZE +: 3];
  assign bus.dst_hburst    = dst_ap[AP_BURST +: 3];
  assign bus.dst_hprot     = dst_ap[AP_PROT +: 4];
  assign bus.dst_hmastlock = dst_ap[AP_LOCK];
  assign bus.dst_hready    = bus.dst_hready_resp;

  assign buf_valid_d = (buf_valid_q | capture) & ~(grant_a & {N_PORTS{bus.dst_hready_resp}});

  // Responses depend only on registered state and the slave, never on src_htrans.
  assign bus.src_hready_resp = ~buf_valid_q & (~grant_dp_q | {N_PORTS{bus.dst_hready_resp}});
  assign bus.src_hresp       = grant_dp_q & {N_PORTS{bus.dst_hresp}};
  assign bus.src_hrdata      = {N_PORTS{bus.dst_hrdata}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= '0;
      grant_dp_q  <= '0;
      lock_dp_q   <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      if (bus.dst_hready_resp) begin
        grant_dp_q <= grant_a;
        lock_dp_q  <= (|grant_a) & dst_ap[AP_LOCK];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_arbiter
// Brief    : Directed self-checking bench for the two-port AHB-lite arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahbl_arbiter;
  import ahbl_arbiter_pkg::*;

  localparam int N_PORTS = 2;
  localparam int W_ADDR  = 32;
  localparam int W_DATA  = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ahbl_arbiter_if #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

  ahbl_arbiter #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Both upstream masters are true masters.
  assign bus.src_hready = bus.src_hready_resp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [1:0] tr, input logic [31:0] addr,
                       input logic wr, input logic lk);
    bus.src_htrans[2*p +: 2]  = tr;
    bus.src_haddr[32*p +: 32] = addr;
    bus.src_hwrite[p]         = wr;
    bus.src_hmastlock[p]      = lk;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.src_haddr       = '0;
    bus.src_hwrite      = '0;
    bus.src_htrans      = '0;
    bus.src_hsize       = {HSIZE_WORD, HSIZE_WORD};
    bus.src_hburst      = '0;
    bus.src_hprot       = {4'b0011, 4'b0011};
    bus.src_hmastlock   = '0;
    bus.src_hwdata      = '0;
    bus.dst_hready_resp = 1'b1;
    bus.dst_hresp       = HRESP_OKAY;
    bus.dst_hrdata      = '0;

    // Reset state
    tick(); tick(); #1;
    check("rst_hready_resp", 64'(bus.src_hready_resp), 64'(2'b11));
    check("rst_hresp",       64'(bus.src_hresp),       64'(2'b00));
    check("rst_dst_htrans",  64'(bus.dst_htrans),      64'(HTRANS_IDLE));
    check("rst_dst_hready",  64'(bus.dst_hready),      64'(1'b1));
    rst_n = 1'b1;

    // Port 0 alone, zero-wait read
    tick();
    drive(0, HTRANS_NSEQ, 32'h2000_0000, 1'b0, 1'b0); #1;
    check("s1_dst_htrans", 64'(bus.dst_htrans),         64'(HTRANS_NSEQ));
    check("s1_dst_haddr",  64'(bus.dst_haddr),          64'(32'h2000_0000));
    check("s1_dst_hsize",  64'(bus.dst_hsize),          64'(HSIZE_WORD));
    check("s1_resp0_a",    64'(bus.src_hready_resp[0]), 64'(1'b1));
    tick();
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    bus.dst_hrdata = 32'hDEAD_BEEF; #1;
    check("s1_hrdata",     64'(bus.src_hrdata[31:0]),   64'(32'hDEAD_BEEF));
    check("s1_resp0_d",    64'(bus.src_hready_resp[0]), 64'(1'b1));
    check("s1_dst_idle",   64'(bus.dst_htrans),         64'(HTRANS_IDLE));

    // Simultaneous requests: port 0 first, port 1 buffered
    tick();
    bus.dst_hrdata = '0;
    drive(0, HTRANS_NSEQ, 32'h100, 1'b0, 1'b0);
    drive(1, HTRANS_NSEQ, 32'h200, 1'b1, 1'b0); #1;
    check("s2_dst_haddr0", 64'(bus.dst_haddr),  64'(32'h100));
    check("s2_dst_hwrite0", 64'(bus.dst_hwrite), 64'(1'b0));
    check("s2_resp_a",     64'(bus.src_hready_resp), 64'(2'b11));
    tick();
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    drive(1, HTRANS_IDLE, 32'h200, 1'b1, 1'b0);
    bus.src_hwdata[63:32] = 32'h55; #1;
    check("s2_resp_b",     64'(bus.src_hready_resp), 64'(2'b01));
    check("s2_dst_haddr1", 64'(bus.dst_haddr),       64'(32'h200));
    check("s2_dst_htrans1", 64'(bus.dst_htrans),     64'(HTRANS_NSEQ));
    check("s2_dst_hwrite1", 64'(bus.dst_hwrite),     64'(1'b1));
    tick(); #1;
    check("s2_hwdata",     64'(bus.dst_hwdata),      64'(32'h55));
    check("s2_resp_c",     64'(bus.src_hready_resp), 64'(2'b11));
    check("s2_dst_idle",   64'(bus.dst_htrans),      64'(HTRANS_IDLE));

    // Three wait states on port 0 while port 1 requests
    tick();
    bus.src_hwdata = '0;
    drive(0, HTRANS_NSEQ, 32'h300, 1'b0, 1'b0); #1;
    check("s3_dst_haddr0", 64'(bus.dst_haddr), 64'(32'h300));
    tick();
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    drive(1, HTRANS_NSEQ, 32'h400, 1'b0, 1'b0);
    bus.dst_hready_resp = 1'b0; #1;
    check("s3_resp_w1",    64'(bus.src_hready_resp), 64'(2'b10));
    tick(); #1;
    check("s3_resp_w2",    64'(bus.src_hready_resp), 64'(2'b00));
    check("s3_dst_hold",   64'(bus.dst_haddr),       64'(32'h400));
    tick(); #1;
    check("s3_resp_w3",    64'(bus.src_hready_resp), 64'(2'b00));
    tick();
    bus.dst_hready_resp = 1'b1; #1;
    check("s3_resp_e",     64'(bus.src_hready_resp), 64'(2'b01));
    check("s3_dst_htrans1", 64'(bus.dst_htrans),     64'(HTRANS_NSEQ));
    check("s3_dst_haddr1", 64'(bus.dst_haddr),       64'(32'h400));
    tick();
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0); #1;
    check("s3_resp_f",     64'(bus.src_hready_resp), 64'(2'b11));

    // Locked sequence on port 1 holds off port 0
    tick();
    drive(1, HTRANS_NSEQ, 32'h500, 1'b0, 1'b1); #1;
    check("s4_dst_lock",   64'(bus.dst_hmastlock), 64'(1'b1));
    check("s4_dst_haddr_a", 64'(bus.dst_haddr),    64'(32'h500));
    tick();
    drive(1, HTRANS_NSEQ, 32'h504, 1'b0, 1'b1);
    drive(0, HTRANS_NSEQ, 32'h600, 1'b0, 1'b0); #1;
    check("s4_dst_haddr_b", 64'(bus.dst_haddr),    64'(32'h504));
    tick();
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0); #1;
    check("s4_resp_c",     64'(bus.src_hready_resp), 64'(2'b10));
    check("s4_dst_haddr_c", 64'(bus.dst_haddr),      64'(32'h600));
    check("s4_dst_unlock", 64'(bus.dst_hmastlock),   64'(1'b0));
    tick();
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0); #1;
    check("s4_resp_d",     64'(bus.src_hready_resp), 64'(2'b11));

    // Two-cycle ERROR response to port 1
    tick();
    drive(1, HTRANS_NSEQ, 32'h700, 1'b0, 1'b0); #1;
    tick();
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    bus.dst_hready_resp = 1'b0;
    bus.dst_hresp       = HRESP_ERROR; #1;
    check("s5_hresp_1",    64'(bus.src_hresp),       64'(2'b10));
    check("s5_resp_1",     64'(bus.src_hready_resp), 64'(2'b01));
    tick();
    bus.dst_hready_resp = 1'b1; #1;
    check("s5_hresp_2",    64'(bus.src_hresp),       64'(2'b10));
    check("s5_resp_2",     64'(bus.src_hready_resp), 64'(2'b11));
    tick();
    bus.dst_hresp = HRESP_OKAY; #1;
    check("s5_hresp_3",    64'(bus.src_hresp),       64'(2'b00));

    // Asynchronous reset while port 1 is buffered
    tick();
    drive(0, HTRANS_NSEQ, 32'h800, 1'b0, 1'b0);
    drive(1, HTRANS_NSEQ, 32'h900, 1'b0, 1'b0); #1;
    tick();
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    bus.dst_hready_resp = 1'b0; #1;
    check("s6_resp_pre",   64'(bus.src_hready_resp), 64'(2'b00));
    #2;
    rst_n = 1'b0;
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0); #1;
    check("s6_buf_valid",  64'(dut.buf_valid_q),     64'(2'b00));
    check("s6_resp_rst",   64'(bus.src_hready_resp), 64'(2'b11));
    check("s6_dst_idle",   64'(bus.dst_htrans),      64'(HTRANS_IDLE));
    check("s6_hresp_rst",  64'(bus.src_hresp),       64'(2'b00));
    bus.dst_hready_resp = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
